// File: rtl/updn_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : updn_counter_param
//  Description : Parameterised up/down counter with programmable step and
//                upper bound (0..limit). Wraps or saturates at the range
//                ends. Provides a synchronous load with clamp-to-limit, a
//                combinational terminal-count flag, registered one-cycle
//                ovf/unf event pulses and a sticky error flag.
//  Ports       : clk        - clock, rising edge active
//                rst_       - asynchronous reset, active-low
//                data_in    - load value (WIDTH)
//                ld_cnt     - synchronous load, active-low
//                updn_cnt   - direction, 1 = up, 0 = down
//                count_enb  - count enable, active-high
//                step       - unsigned increment/decrement (STEP_W)
//                limit      - inclusive upper bound of the count (WIDTH)
//                data_out   - registered count (WIDTH)
//                tc         - terminal count (combinational)
//                ovf / unf  - registered up/down range-event pulses
//                err        - sticky flag: a load value exceeded limit
//  Revision    : 1.0 - initial release
// ============================================================================
module updn_counter_param #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0,
    parameter int STEP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld_cnt,
    input  logic              updn_cnt,
    input  logic              count_enb,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              err
);

    // Wide enough that data_out + step can never truncate.
    localparam int c_SUM_W = WIDTH + STEP_W + 1;

    logic [WIDTH-1:0]   r_data;
    logic               r_ovf;
    logic               r_unf;
    logic               r_err;

    logic [c_SUM_W-1:0] w_sum;
    logic               w_up_over;
    logic               w_dn_under;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_up_bound_val;
    logic [WIDTH-1:0]   w_dn_bound_val;

    logic [WIDTH-1:0]   w_nxt_data;
    logic               w_nxt_ovf;
    logic               w_nxt_unf;
    logic               w_nxt_err;

    assign w_sum      = c_SUM_W'(r_data) + c_SUM_W'(step);
    assign w_up_over  = w_sum > c_SUM_W'(limit);
    assign w_dn_under = c_SUM_W'(step) > c_SUM_W'(r_data);
    // Only consumed when step <= r_data, so narrowing step here is safe.
    assign w_diff     = r_data - WIDTH'(step);

    // Value taken when a count runs past a range end.
    generate
        if (SATURATE) begin : g_saturate
            assign w_up_bound_val = limit;
            assign w_dn_bound_val = '0;
        end else begin : g_wrap
            assign w_up_bound_val = '0;
            assign w_dn_bound_val = limit;
        end
    endgenerate

    always_comb begin
        w_nxt_data = r_data;
        w_nxt_ovf  = 1'b0;
        w_nxt_unf  = 1'b0;
        w_nxt_err  = r_err;
        if (!ld_cnt) begin
            if (data_in > limit) begin
                w_nxt_data = limit;
                w_nxt_err  = 1'b1;
            end else begin
                w_nxt_data = data_in;
            end
        end else if (count_enb) begin
            if (r_data > limit) begin
                // limit was lowered beneath the count: pull back into range
                w_nxt_data = limit;
                w_nxt_ovf  = 1'b1;
            end else if (step == '0) begin
                w_nxt_data = r_data;
            end else if (updn_cnt) begin
                if (w_up_over) begin
                    w_nxt_data = w_up_bound_val;
                    w_nxt_ovf  = 1'b1;
                end else begin
                    w_nxt_data = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_under) begin
                    w_nxt_data = w_dn_bound_val;
                    w_nxt_unf  = 1'b1;
                end else begin
                    w_nxt_data = w_diff;
                end
            end
        end
    end

    // All state shares one reset so release is seen by every flop together.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_data <= w_nxt_data;
            r_ovf  <= w_nxt_ovf;
            r_unf  <= w_nxt_unf;
            r_err  <= w_nxt_err;
        end
    end

    assign data_out = r_data;
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    assign err      = r_err;
    assign tc       = count_enb & (updn_cnt ? (r_data == limit) : (r_data == '0));

endmodule
`default_nettype wire

// File: doc/updn_counter_param.md
UPDN_COUNTER_PARAM -- requirements
Module: updn_counter_param

Interface
REQ-001 Parameter WIDTH, default 16: counter, data_in, limit and data_out width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = saturate at the range ends.
REQ-003 Parameter STEP_W, default 4: width of the step input.
REQ-004 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 Port rst_  input  1: reset, asynchronous, active-low.
REQ-006 Port data_in  input  WIDTH: load value.
REQ-007 Port ld_cnt  input  1: synchronous load, active-low.
REQ-008 Port updn_cnt  input  1: count direction, 1 = up, 0 = down.
REQ-009 Port count_enb  input  1: count enable, active-high.
REQ-010 Port step  input  STEP_W: increment/decrement magnitude, unsigned.
REQ-011 Port limit  input  WIDTH: upper bound; legal count range is 0..limit inclusive.
REQ-012 Port data_out  output  WIDTH: registered count value.
REQ-013 Port tc  output  1: terminal count, combinational.
REQ-014 Port ovf  output  1: registered one-cycle pulse marking an up-count range event.
REQ-015 Port unf  output  1: registered one-cycle pulse marking a down-count range event.
REQ-016 Port err  output  1: sticky error flag, registered.

Function
REQ-017 Priority per rising edge SHALL be: rst_ low, then ld_cnt low, then count_enb high, then hold.
REQ-018 Load (ld_cnt=0): data_out SHALL take data_in; if data_in > limit, data_out SHALL take limit and err SHALL set.
REQ-019 Load SHALL override count_enb in the same cycle; ovf and unf SHALL be 0 after a load cycle.
REQ-020 Up count (count_enb=1, updn_cnt=1): sum = data_out + step, computed in WIDTH+STEP_W+1 bits with no truncation.
REQ-021 Up count, sum <= limit: data_out SHALL take sum.
REQ-022 Up count, sum > limit: data_out SHALL take 0 when SATURATE=0 or limit when SATURATE=1; ovf SHALL pulse in the following cycle.
REQ-023 Down count (count_enb=1, updn_cnt=0): if step <= data_out, data_out SHALL take data_out - step.
REQ-024 Down count, step > data_out: data_out SHALL take limit when SATURATE=0 or 0 when SATURATE=1; unf SHALL pulse in the following cycle.
REQ-025 Saturate mode: a count already at the bound that would exceed it SHALL hold data_out and still pulse ovf or unf.
REQ-026 step = 0 with count_enb=1: data_out SHALL hold and no ovf or unf SHALL be raised.
REQ-027 Out of range: if data_out > limit on an enabled count (limit lowered at run time), data_out SHALL take limit regardless of direction or mode, and ovf SHALL pulse.
REQ-028 ovf and unf SHALL be 0 in every cycle not directly following a range event; they SHALL never be high together.
REQ-029 tc SHALL be 1 when count_enb=1 and either (updn_cnt=1 and data_out==limit) or (updn_cnt=0 and data_out==0); otherwise tc SHALL be 0.
REQ-030 err SHALL clear only on reset; further loads SHALL NOT clear it.
REQ-031 The count SHALL have a latency of one clock from enable to updated data_out, sustaining one count per cycle.

Reset
REQ-032 While rst_ is low, data_out, ovf, unf and err SHALL be 0 immediately, independent of clk.
REQ-033 A rst_ assertion mid-count SHALL abort the in-flight operation; the first edge after rst_ deasserts SHALL obey REQ-017.
REQ-034 Reset deassertion SHALL be clean against clk: no partial update is permitted on the first edge.

Verification
REQ-035 WIDTH=16, SATURATE=0, limit=9, step=1: load 2, count up 8 cycles -> data_out 3..9, then 0; ovf pulses once; tc high while data_out=9.
REQ-036 Same configuration, load 1, count down with step=3 -> data_out 1 -> 9 with unf pulse; next count -> 6.
REQ-037 SATURATE=1, limit=9, step=4: load 7, count up twice -> data_out 9 with ovf pulse, then 9 held with a second ovf pulse.
REQ-038 Load data_in=20 with limit=9 and count_enb=1 in the same cycle -> data_out=9, err=1; err stays 1 after a later load of 3.
REQ-039 data_out=8, change limit to 5, count down step=1 -> data_out=5 with an ovf pulse; step=0 with count_enb=1 -> hold, no pulses.
REQ-040 Assert rst_ asynchronously between edges mid-count -> data_out, ovf, unf, err read 0 before the next edge; counting resumes from 0.
